// File: rtl/lcd_pixel_capture.sv
// LCD-side pixel receiver: oversamples ld0/ld1/cp/st/s, rebuilds x/y and queues {addr,shade} writes.
// Optional macro LCD_PIXEL_CAPTURE_CRC_EN adds a per-frame CRC-16-CCITT output (frame_crc).
module lcd_pixel_capture #(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 144,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld0,
  input  logic        ld1,
  input  logic        cp,
  input  logic        st,
  input  logic        s,
  input  logic        clr_err,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [14:0] wr_addr,
  output logic [1:0]  wr_data,
  output logic        frame_done,
  output logic        err_geom,
`ifdef LCD_PIXEL_CAPTURE_CRC_EN
  output logic        err_ovf,
  output logic [15:0] frame_crc
`else
  output logic        err_ovf
`endif
);
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [14:0] LAST_ADDR = 15'(WIDTH * HEIGHT - 1);

  if (WIDTH * HEIGHT - 1 >= 32768) begin : g_addr_check
    $error("lcd_pixel_capture: WIDTH*HEIGHT does not fit the 15-bit address");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("lcd_pixel_capture: FIFO_DEPTH must be a power of two >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_sync_check
    $error("lcd_pixel_capture: SYNC_STAGES must be >= 2");
  end

  // Pin bundle order: {s, st, cp, ld1, ld0}
  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] pins;
  logic       cp_prev, st_prev;

  assign pins = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      cp_prev <= 1'b0;
      st_prev <= 1'b0;
    end else begin
      sync_q[0] <= {s, st, cp, ld1, ld0};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      cp_prev <= pins[2];
      st_prev <= pins[3];
    end
  end

  // Edge events are registered once so wr_valid rises SYNC_STAGES+2 clocks after cp falls
  logic       ev_pix, ev_line, ev_s;
  logic [1:0] ev_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_pix  <= 1'b0;
      ev_line <= 1'b0;
      ev_s    <= 1'b0;
      ev_data <= '0;
    end else begin
      ev_pix  <= cp_prev & ~pins[2];
      ev_line <= ~st_prev & pins[3];
      ev_s    <= pins[4];
      ev_data <= pins[1:0];
    end
  end

  logic [XW-1:0] x, x_line, x_next;
  logic [YW-1:0] y, y_line;
  logic          in_frame, frame_line;
  logic          geom_set, ovf_set, push, pop, full;
  logic [14:0]   push_addr;

  always_comb begin
    x_line     = x;
    y_line     = y;
    frame_line = in_frame;
    geom_set   = 1'b0;
    ovf_set    = 1'b0;
    push       = 1'b0;
    if (ev_line) begin
      if (ev_s) begin
        x_line     = '0;
        y_line     = '0;
        frame_line = 1'b1;
      end else if (in_frame) begin
        x_line = '0;
        if (y >= YW'(HEIGHT - 1)) begin
          y_line   = YW'(HEIGHT);
          geom_set = 1'b1;
        end else begin
          y_line = y + YW'(1);
        end
      end
    end
    x_next = x_line;
    if (ev_pix && frame_line) begin
      if (x_line >= XW'(WIDTH) || y_line >= YW'(HEIGHT)) begin
        geom_set = 1'b1;
      end else begin
        x_next = x_line + XW'(1);
        if (full && !pop) ovf_set = 1'b1;
        else              push    = 1'b1;
      end
    end
  end

  assign push_addr = 15'(y_line) * 15'(WIDTH) + 15'(x_line);

  always_ff @(posedge clk) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      in_frame   <= 1'b0;
      err_geom   <= 1'b0;
      err_ovf    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      x          <= x_next;
      y          <= y_line;
      in_frame   <= frame_line;
      err_geom   <= (err_geom & ~clr_err) | geom_set;
      err_ovf    <= (err_ovf & ~clr_err) | ovf_set;
      frame_done <= push && (push_addr == LAST_ADDR);
    end
  end

  logic [16:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;

  assign wr_valid = (count != '0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign pop      = wr_valid & wr_ready;
  assign {wr_addr, wr_data} = wr_valid ? mem[rp] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= {push_addr, ev_data};
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

`ifdef LCD_PIXEL_CAPTURE_CRC_EN
  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  logic [15:0] crc_run, crc_base, crc_new;

  always_comb begin
    crc_base = (ev_line & ev_s) ? 16'hFFFF : crc_run;
    crc_new  = crc_bit(crc_bit(crc_base, ev_data[1]), ev_data[0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_run   <= 16'hFFFF;
      frame_crc <= '0;
    end else if (push) begin
      if (push_addr == LAST_ADDR) begin
        frame_crc <= crc_new;
        crc_run   <= 16'hFFFF;
      end else begin
        crc_run <= crc_new;
      end
    end else begin
      crc_run <= crc_base;
    end
  end
`endif
endmodule

// File: tb/tb_lcd_pixel_capture.sv
// Scoreboard bench for lcd_pixel_capture: random pin stimulus against a coordinate-level reference model.
module tb_lcd_pixel_capture;
  localparam int W     = 160;
  localparam int H     = 12;
  localparam int DEPTH = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic ld0 = 1'b0, ld1 = 1'b0, cp = 1'b0, st = 1'b0, s = 1'b0, clr_err = 1'b0;
  logic wr_ready = 1'b1;
  logic wr_valid, frame_done, err_geom, err_ovf;
  logic [14:0] wr_addr;
  logic [1:0]  wr_data;
`ifdef LCD_PIXEL_CAPTURE_CRC_EN
  logic [15:0] frame_crc;
`endif

  lcd_pixel_capture #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .ld0(ld0), .ld1(ld1), .cp(cp), .st(st), .s(s),
    .clr_err(clr_err), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .err_geom(err_geom),
`ifdef LCD_PIXEL_CAPTURE_CRC_EN
    .err_ovf(err_ovf), .frame_crc(frame_crc)
`else
    .err_ovf(err_ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [16:0] exp_q[$];
  int fd_seen = 0, fd_exp = 0;

  // Reference model state: pixel coordinates and expected sticky flags
  int mx = 0, my = 0;
  bit minf = 0, m_geom = 0, m_ovf = 0;
  bit stalling = 0;
  int stall_fill = 0;
  logic [15:0] m_crc = 16'hFFFF, m_fcrc = 16'h0000;

  function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [1:0] d);
    logic [15:0] c;
    c = c_in;
    for (int k = 1; k >= 0; k--) begin
      c = c ^ {d[k], 15'b0};
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_line(input bit sv);
    if (sv) begin
      mx = 0; my = 0; minf = 1; m_crc = 16'hFFFF;
    end else if (minf) begin
      mx = 0;
      my = (my + 1 >= H) ? H : my + 1;
      if (my == H) m_geom = 1;
    end
  endtask

  task automatic model_pix(input logic [1:0] d);
    int addr;
    if (!minf) return;
    if (mx >= W || my >= H) begin
      m_geom = 1;
      return;
    end
    addr = my * W + mx;
    mx++;
    if (stalling && stall_fill >= DEPTH) begin
      m_ovf = 1;
      return;
    end
    if (stalling) stall_fill++;
    exp_q.push_back({15'(addr), d});
    m_crc = crc_ref(m_crc, d);
    if (addr == W * H - 1) begin
      fd_exp++;
      m_fcrc = m_crc;
      m_crc  = 16'hFFFF;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [1:0] d, input int gap);
    {ld1, ld0} = d;
    cp = 1'b1;
    tick(2);
    cp = 1'b0;
    model_pix(d);
    tick(2 + gap);
  endtask

  task automatic line(input bit sv);
    s  = sv;
    st = 1'b1;
    model_line(sv);
    tick(2);
    st = 1'b0;
    s  = 1'b0;
    tick(2);
  endtask

  task automatic frame(input int mode);
    logic [1:0] d;
    line(1'b1);
    for (int yy = 0; yy < H; yy++) begin
      if (yy > 0) line(1'b0);
      for (int xx = 0; xx < W; xx++) begin
        d = (mode == 0) ? 2'((xx + yy) % 4) : (mode == 1) ? 2'($urandom) : 2'b00;
        pixel(d, (mode == 1) ? int'($urandom_range(0, 2)) : 0);
      end
    end
  endtask

  task automatic drain();
    int n;
    tick(8);
    n = 0;
    while ((exp_q.size() != 0 || wr_valid) && n < 400) begin
      tick(1);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("frame_done_count", fd_seen, fd_exp);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_err_geom"}, err_geom, m_geom);
    check({tag, "_err_ovf"}, err_ovf, m_ovf);
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    m_geom = 0;
    m_ovf  = 0;
    tick(1);
    check_flags("after_clr");
  endtask

  // Monitor: pops the scoreboard on every accepted write and checks hold stability
  initial begin
    logic [16:0] e, hold_v;
    bit hold;
    hold = 0;
    hold_v = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 0;
      end else begin
        if (hold) check("hold_stable", {wr_valid, wr_addr, wr_data}, {1'b1, hold_v});
        if (frame_done) fd_seen++;
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %0d expected no write", wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", wr_addr, e[16:2]);
            check("wr_data", wr_data, e[1:0]);
          end
        end
        hold   = wr_valid && !wr_ready;
        hold_v = {wr_addr, wr_data};
      end
    end
  end

  initial begin
    #900us;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
`ifdef LCD_PIXEL_CAPTURE_CRC_EN
    logic [15:0] crc_first;
`endif
    tick(3);
    check("reset_wr_valid", wr_valid, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_err_geom", err_geom, 0);
    check("reset_err_ovf", err_ovf, 0);
    reset = 1'b0;
    tick(2);

    // Activity before any frame start is ignored
    for (int i = 0; i < 3; i++) pixel(2'($urandom), 0);
    line(1'b0);
    for (int i = 0; i < 2; i++) pixel(2'($urandom), 0);
    drain();
    check_flags("preframe");

    frame(0);
    drain();
    check_flags("frame0");

    // Line past the last one saturates y and flags geometry
    line(1'b0);
    pixel(2'd1, 0);
    drain();
    check_flags("y_overflow");
    clear_errs();

    // st rising and cp falling in the same clock
    {ld1, ld0} = 2'd3;
    cp = 1'b1;
    s  = 1'b1;
    tick(2);
    cp = 1'b0;
    st = 1'b1;
    model_line(1'b1);
    model_pix(2'd3);
    tick(2);
    st = 1'b0;
    s  = 1'b0;
    tick(2);
    drain();
    check_flags("simul");

    // Over-long line
    line(1'b1);
    for (int i = 0; i < W + 5; i++) pixel(2'($urandom), 0);
    drain();
    check_flags("long_line");
    clear_errs();

    // Output stall overflows the FIFO
    line(1'b1);
    wr_ready   = 1'b0;
    stalling   = 1;
    stall_fill = 0;
    for (int i = 0; i < 10; i++) pixel(2'($urandom), 0);
    tick(150);
    check("stall_wr_valid", wr_valid, 1);
    check_flags("stall");
    wr_ready = 1'b1;
    stalling = 0;
    drain();
    for (int i = 0; i < 5; i++) pixel(2'($urandom), 0);
    drain();
    clear_errs();

    frame(1);
    drain();
    check_flags("random_frame");

`ifdef LCD_PIXEL_CAPTURE_CRC_EN
    frame(2);
    drain();
    check("crc_zero_frame1", frame_crc, m_fcrc);
    crc_first = frame_crc;
    frame(2);
    drain();
    check("crc_zero_frame2", frame_crc, m_fcrc);
    check("crc_repeatable", frame_crc, crc_first);
`endif

    // Reset mid-line with three entries queued
    line(1'b1);
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) pixel(2'($urandom), 0);
    tick(8);
    reset = 1'b1;
    tick(1);
    check("midreset_wr_valid", wr_valid, 0);
    check("midreset_frame_done", frame_done, 0);
    check("midreset_err_geom", err_geom, 0);
    check("midreset_err_ovf", err_ovf, 0);
    exp_q.delete();
    minf = 0; mx = 0; my = 0; m_geom = 0; m_ovf = 0;
    reset = 1'b0;
    wr_ready = 1'b1;
    tick(2);
    pixel(2'd2, 0);
    drain();
    check_flags("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
